// File: rtl/majority.sv
// Registered 3-lane TMR majority voter with unanimity flag, dissenting-lane
// index and saturating per-lane dissent counters.
module majority #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       A,
  input  logic             clr_cnt,
  output logic             OUT,
  output logic             out_valid,
  output logic             unanimous,
  output logic [1:0]       dissent,
  output logic [CNT_W-1:0] dissent_cnt0,
  output logic [CNT_W-1:0] dissent_cnt1,
  output logic [CNT_W-1:0] dissent_cnt2
);

  logic             maj;
  logic             unan;
  logic [1:0]       dis_idx;
  logic [CNT_W-1:0] cnt [3];

  always_comb begin
    maj  = (A[2] & A[1]) | (A[2] & A[0]) | (A[1] & A[0]);
    unan = (A == 3'b000) || (A == 3'b111);
    // Only one lane can disagree with the majority of three.
    if (unan)             dis_idx = 2'd3;
    else if (A[0] != maj) dis_idx = 2'd0;
    else if (A[1] != maj) dis_idx = 2'd1;
    else                  dis_idx = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      OUT       <= 1'b0;
      out_valid <= 1'b0;
      unanimous <= 1'b1;
      dissent   <= 2'd3;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        OUT       <= maj;
        unanimous <= unan;
        dissent   <= dis_idx;
      end
      if (clr_cnt) begin
        for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
      end else if (in_valid && !unan) begin
        for (int unsigned i = 0; i < 3; i++)
          if (dis_idx == 2'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign dissent_cnt0 = cnt[0];
  assign dissent_cnt1 = cnt[1];
  assign dissent_cnt2 = cnt[2];

endmodule

// File: tb/tb_majority.sv
// Directed self-checking bench for majority: exhaustive vote, hold,
// counter clear/priority, saturation (narrow instance) and mid-stream reset.
module tb_majority;

  logic       clk = 1'b0;
  logic       rst, in_valid, clr_cnt;
  logic [2:0] A;
  logic       OUT, out_valid, unanimous;
  logic [1:0] dissent;
  logic [7:0] c0, c1, c2;

  logic       in_valid2;
  logic [2:0] A2;
  logic       OUT2, out_valid2, unanimous2;
  logic [1:0] dissent2;
  logic [1:0] s0, s1, s2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_out [8];
  logic [7:0] exp_dis [8];

  always #5 clk = ~clk;

  majority #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .clr_cnt(clr_cnt),
    .OUT(OUT), .out_valid(out_valid), .unanimous(unanimous), .dissent(dissent),
    .dissent_cnt0(c0), .dissent_cnt1(c1), .dissent_cnt2(c2)
  );

  majority #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .A(A2), .clr_cnt(1'b0),
    .OUT(OUT2), .out_valid(out_valid2), .unanimous(unanimous2), .dissent(dissent2),
    .dissent_cnt0(s0), .dissent_cnt1(s1), .dissent_cnt2(s2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    exp_out = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1};
    exp_dis = '{8'd3, 8'd0, 8'd1, 8'd2, 8'd2, 8'd1, 8'd0, 8'd3};
    rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0; A = 3'b000;
    in_valid2 = 1'b0; A2 = 3'b000;
    tick(); tick();

    chk("rst_out", OUT, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_unanimous", unanimous, 1);
    chk("rst_dissent", dissent, 3);
    chk("rst_cnt0", c0, 0);
    chk("rst_cnt1", c1, 0);
    chk("rst_cnt2", c2, 0);
    rst = 1'b0;

    for (int a = 0; a < 8; a++) begin
      A = 3'(a); in_valid = 1'b1;
      tick();
      chk($sformatf("exh_out_%0d", a), OUT, exp_out[a]);
      chk($sformatf("exh_dissent_%0d", a), dissent, exp_dis[a]);
      chk($sformatf("exh_valid_%0d", a), out_valid, 1);
      chk($sformatf("exh_unan_%0d", a), unanimous, (a == 0 || a == 7) ? 1 : 0);
    end
    chk("exh_cnt0", c0, 2);
    chk("exh_cnt1", c1, 2);
    chk("exh_cnt2", c2, 2);

    A = 3'b011; in_valid = 1'b1;
    tick();
    chk("hold_accept_out", OUT, 1);
    in_valid = 1'b0; A = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold_out_%0d", k), OUT, 1);
      chk($sformatf("hold_valid_%0d", k), out_valid, 0);
      chk($sformatf("hold_dissent_%0d", k), dissent, 2);
      chk($sformatf("hold_cnt2_%0d", k), c2, 3);
    end

    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_idle_cnt0", c0, 0);
    chk("clr_idle_cnt2", c2, 0);

    A = 3'b001; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("cnt_cnt0", c0, 5);
    chk("cnt_cnt1", c1, 0);
    chk("cnt_cnt2", c2, 0);
    chk("cnt_unanimous", unanimous, 0);

    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clrv_cnt0", c0, 0);
    chk("clrv_cnt1", c1, 0);
    chk("clrv_cnt2", c2, 0);
    chk("clrv_out", OUT, 0);
    chk("clrv_valid", out_valid, 1);
    chk("clrv_dissent", dissent, 0);
    in_valid = 1'b0;

    A2 = 3'b110; in_valid2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("sat_cnt0_%0d", k), s0, (k < 3) ? k + 1 : 3);
    end
    in_valid2 = 1'b0;
    chk("sat_cnt1", s1, 0);
    chk("sat_out", OUT2, 1);

    A = 3'b001; in_valid = 1'b1;
    tick(); tick();
    chk("pre_rst_cnt0", c0, 2);
    rst = 1'b1; A = 3'b111; in_valid = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out", OUT, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_dissent", dissent, 3);
    chk("mrst_unanimous", unanimous, 1);
    chk("mrst_cnt0", c0, 0);
    chk("mrst_sat_cnt0", s0, 0);
    tick();
    chk("post_rst_out", OUT, 1);
    chk("post_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("post_rst_valid_drop", out_valid, 0);
    chk("post_rst_hold", OUT, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
